// File: rtl/lcv_div_pkg.sv
// Shared types and constants for the multi-cycle divider.
//   div_state_t        : divider FSM state encoding
//   DIV_WIDTH_DEFAULT  : default operand/result width
package lcv_div_pkg;

   localparam int DIV_WIDTH_DEFAULT = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PREP  = 3'd1,
      ST_ITER  = 3'd2,
      ST_FIXUP = 3'd3,
      ST_DONE  = 3'd4
   } div_state_t;

endpackage

// File: rtl/lcv_div_step.sv
// One radix-2 restoring division step (purely combinational).
// Ports:
//   rem_in   [WIDTH:0]   partial remainder before the step
//   dvd_in   [WIDTH-1:0] dividend/quotient shift register; MSB is the next dividend bit
//   dvs      [WIDTH-1:0] divisor magnitude
//   rem_out  [WIDTH:0]   partial remainder after the step
//   dvd_out  [WIDTH-1:0] dvd_in shifted left with the new quotient bit in the LSB
module lcv_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic [WIDTH-1:0] dvd_in,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH:0]   rem_out,
   output logic [WIDTH-1:0] dvd_out
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic             q_bit;

   always_comb begin
      shifted = {rem_in[WIDTH-1:0], dvd_in[WIDTH-1]};
      diff    = {1'b0, shifted} - {2'b00, dvs};
      // A set rem_in MSB means the true shifted value exceeds any divisor,
      // so the subtract always succeeds; diff[WIDTH:0] is still exact.
      q_bit   = rem_in[WIDTH] | ~diff[WIDTH+1];
      rem_out = q_bit ? diff[WIDTH:0] : shifted;
      dvd_out = {dvd_in[WIDTH-2:0], q_bit};
   end

endmodule

// File: rtl/lcv_div_multi_cycle.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per clock.
// Fixed latency: outp_valid rises WIDTH+2 cycles after the accepting edge.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   inp_valid/inp_ready request handshake (ready only in IDLE)
//   inp_a, inp_b        dividend, divisor
//   inp_signed          1 = two's-complement, 0 = unsigned
//   outp_valid/outp_ready result handshake
//   outp_quot, outp_rem quotient, remainder (truncating division)
//   outp_div_by_zero    divisor was zero
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a request, inp_ready high
// ST_PREP  | form magnitudes, record signs and special cases
// ST_ITER  | one restoring step per cycle, WIDTH cycles
// ST_FIXUP | apply signs / special-case results to output registers
// ST_DONE  | outp_valid high until consumer accepts
module lcv_div_multi_cycle
   import lcv_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inp_valid,
   output logic             inp_ready,
   input  logic [WIDTH-1:0] inp_a,
   input  logic [WIDTH-1:0] inp_b,
   input  logic             inp_signed,
   output logic             outp_valid,
   input  logic             outp_ready,
   output logic [WIDTH-1:0] outp_quot,
   output logic [WIDTH-1:0] outp_rem,
   output logic             outp_div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   div_state_t       state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             sgn_reg;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   prem;
   logic [CW-1:0]    cnt;
   logic             q_neg;
   logic             r_neg;
   logic             dbz;
   logic             ovf;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             is_dbz;
   logic             is_ovf;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;

   logic [WIDTH:0]   step_rem;
   logic [WIDTH-1:0] step_dvd;

   lcv_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (prem),
      .dvd_in  (dvd),
      .dvs     (dvs),
      .rem_out (step_rem),
      .dvd_out (step_dvd)
   );

   always_comb begin
      a_neg  = sgn_reg & a_reg[WIDTH-1];
      b_neg  = sgn_reg & b_reg[WIDTH-1];
      a_mag  = a_neg ? -a_reg : a_reg;
      b_mag  = b_neg ? -b_reg : b_reg;
      is_dbz = (b_reg == '0);
      is_ovf = sgn_reg & (a_reg == {1'b1, {(WIDTH-1){1'b0}}}) & (b_reg == '1);

      if (dbz) begin
         quot_fix = '1;
         rem_fix  = a_reg;
      end else if (ovf) begin
         quot_fix = a_reg;
         rem_fix  = '0;
      end else begin
         quot_fix = q_neg ? -dvd : dvd;
         rem_fix  = r_neg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         inp_ready        <= 1'b1;
         outp_valid       <= 1'b0;
         outp_quot        <= '0;
         outp_rem         <= '0;
         outp_div_by_zero <= 1'b0;
         a_reg            <= '0;
         b_reg            <= '0;
         sgn_reg          <= 1'b0;
         dvd              <= '0;
         dvs              <= '0;
         prem             <= '0;
         cnt              <= '0;
         q_neg            <= 1'b0;
         r_neg            <= 1'b0;
         dbz              <= 1'b0;
         ovf              <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (inp_valid && inp_ready) begin
                  a_reg     <= inp_a;
                  b_reg     <= inp_b;
                  sgn_reg   <= inp_signed;
                  inp_ready <= 1'b0;
                  state     <= ST_PREP;
               end
            end
            ST_PREP: begin
               dvd   <= a_mag;
               dvs   <= b_mag;
               prem  <= '0;
               q_neg <= a_neg ^ b_neg;
               r_neg <= a_neg;
               dbz   <= is_dbz;
               ovf   <= is_ovf;
               cnt   <= CW'(WIDTH - 1);
               state <= ST_ITER;
            end
            ST_ITER: begin
               prem <= step_rem;
               dvd  <= step_dvd;
               if (cnt == '0) begin
                  state <= ST_FIXUP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_FIXUP: begin
               outp_quot        <= quot_fix;
               outp_rem         <= rem_fix;
               outp_div_by_zero <= dbz;
               outp_valid       <= 1'b1;
               state            <= ST_DONE;
            end
            ST_DONE: begin
               if (outp_ready) begin
                  outp_valid <= 1'b0;
                  inp_ready  <= 1'b1;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               state     <= ST_IDLE;
               inp_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
